reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised power-on/reset sequencer for the iCE40 designs, generalising the fixed 10-cycle reset counter currently in the top level. Driven by the internal oscillator clock, it holds all downstream domains in reset for a programmable time, releases CHANNELS reset outputs in staggered order, and re-enters reset on a synchronised external request. It sits directly beside the oscillator instance and feeds `reset` of the I2C generator, I2C-to-serial core and any future domains.

## Interface
- CHANNELS, 2: number of staged reset outputs (>=1)
- HOLD_CYCLES, 10: cycles all outputs stay asserted after the last reset/request (>=1)
- STAGE_GAP, 4: cycles between consecutive channel releases (>=0)
- REQ_SYNC_STAGES, 2: synchroniser depth for `req` (>=2)
- WDT_CYCLES, 24000000: watchdog timeout in cycles (used only with RESET_SEQ_WDT_EN)

- clk  in  1  system clock (oscillator, 24 MHz)
- reset  in  1  synchronous, active-high; power-on reset from the POR counter
- req  in  1  asynchronous active-high reset request (button/host), level-sensitive
- rst_out  out  CHANNELS  active-high per-domain resets; bit 0 released first
- ready  out  1  high when every channel is released
- wdt_kick  in  1  watchdog service pulse (only with RESET_SEQ_WDT_EN)
- wdt_fired  out  1  sticky: watchdog caused a reset (only with RESET_SEQ_WDT_EN)

## Operation
- One clock; reset is synchronous and active-high.
- Reset values: rst_out all ones, ready 0, state HOLD, counter 0, stage index 0, wdt_fired 0, synchroniser flops 0.
- States: HOLD, RELEASE, RUN.
- HOLD: rst_out all ones, ready 0. Counter increments per edge; at count HOLD_CYCLES-1 -> RELEASE, rst_out[0] cleared that edge, counter cleared.
- RELEASE: counter increments; at count STAGE_GAP-1 clear next rst_out bit, counter cleared, stage++. When rst_out[CHANNELS-1] clears, ready sets same edge, -> RUN.
- STAGE_GAP=0: all bits clear on the HOLD exit edge, ready set same edge, direct HOLD->RUN.
- CHANNELS=1: HOLD exit clears rst_out[0] and sets ready, -> RUN.
- RUN: outputs static until a restart event.
- Restart event (req_sync high, or watchdog expiry): from any state -> HOLD next edge, rst_out all ones, ready 0, counter cleared. While req_sync stays high, counter held at 0.
- `reset` overrides everything, including req and watchdog.
- Counter width $clog2(max(HOLD_CYCLES,STAGE_GAP,2)); no wrap possible before compare.

## Timing
- Edge 1 = first rising edge with reset low and req_sync low.
- rst_out[k] falls at edge HOLD_CYCLES + k*STAGE_GAP.
- ready rises at edge HOLD_CYCLES + (CHANNELS-1)*STAGE_GAP.
- req to reassertion latency: REQ_SYNC_STAGES+1 edges.
- Restart mid-RELEASE: already-released bits reassert on the next edge; full sequence reruns.

## Configuration
- RESET_SEQ_WDT_EN defined: wdt_kick/wdt_fired ports and a watchdog counter exist. Counter runs only in RUN, cleared by wdt_kick or any non-RUN state. At WDT_CYCLES-1 without a kick: restart event, wdt_fired set (cleared only by `reset`).
- Undefined: ports absent, no watchdog logic; only reset and req restart.

## Structure
- Package reset_seq_pkg: state enum (HOLD, RELEASE, RUN), counter-width function.
- Sub-module req_sync: REQ_SYNC_STAGES-deep flop chain, reset to 0; reusable for scl/sda inputs.

## Test plan
- CHANNELS=3, HOLD=10, GAP=4; reset high 5 cycles then low -> rst_out 111 until edge 10, 110 at 10, 100 at 14, 000 with ready=1 at 18.
- In RUN, 1-cycle req pulse -> rst_out 111, ready 0 three edges later; rst_out 110 ten edges after req_sync falls.
- req during RELEASE (rst_out=110) -> 111 next edge after sync; sequence restarts from HOLD_CYCLES.
- GAP=0, CHANNELS=4 -> rst_out 1111 to 0000 and ready=1 at edge 10 exactly.
- WDT_EN, WDT_CYCLES=20: no kicks -> 20 edges after ready, rst_out 111, wdt_fired 1, re-release; kicks every 10 cycles -> stays in RUN 1000 cycles, wdt_fired 0.
- reset asserted for 1 cycle in RUN with req high -> all outputs reset values; release timing restarts only after req_sync low.

Source files
------------

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and helpers for the reset sequencer.
//               - seq_state_t : sequencer states HOLD / RELEASE / RUN
//               - cnt_width() : width of the hold/gap counter
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Explicit 2-bit encoding; the fourth code is unused and recovers to HOLD.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    // The counter only ever reaches max(HOLD_CYCLES, STAGE_GAP) - 1 before it
    // is compared and cleared, so $clog2 of that maximum (floored at 2 so the
    // counter is never zero bits wide) is always enough.
    function automatic int cnt_width(input int hold_cycles, input int stage_gap);
        int m;
        m = 2;
        if (hold_cycles > m) m = hold_cycles;
        if (stage_gap > m)   m = stage_gap;
        return $clog2(m);
    endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/req_sync.sv
`default_nettype none
// ============================================================================
// Module      : req_sync
// Description : STAGES-deep flop chain bringing an asynchronous level into the
//               clk domain. All flops clear on rst. Generic enough to reuse
//               for scl/sda pin inputs.
// Ports       : clk     - sampling clock
//               rst     - synchronous active-high reset (chain -> 0)
//               i_async - asynchronous input level
//               o_sync  - synchronised level, STAGES edges behind i_async
// Revision    : 1.0 - initial release
// ============================================================================
module req_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule : req_sync
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Power-on / request-driven reset sequencer. Holds every
//               downstream domain in reset for HOLD_CYCLES, then releases the
//               CHANNELS outputs one at a time, STAGE_GAP cycles apart, bit 0
//               first. A synchronised req (or a watchdog expiry) restarts the
//               whole sequence from HOLD.
// Ports       : clk       - oscillator clock
//               reset     - synchronous active-high power-on reset
//               req       - asynchronous active-high restart request (level)
//               rst_out   - per-domain active-high resets
//               ready     - high once every channel is released
//               wdt_kick  - watchdog service pulse    (RESET_SEQ_WDT_EN only)
//               wdt_fired - sticky watchdog-reset flag (RESET_SEQ_WDT_EN only)
// Options     : RESET_SEQ_WDT_EN - define to build the watchdog and its ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int HOLD_CYCLES     = 10,
    parameter int STAGE_GAP       = 4,
    parameter int REQ_SYNC_STAGES = 2
`ifdef RESET_SEQ_WDT_EN
    ,
    parameter int WDT_CYCLES      = 24000000
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
`ifdef RESET_SEQ_WDT_EN
    input  logic                wdt_kick,
    output logic                wdt_fired,
`endif
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready
);

    localparam int c_CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int c_STG_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
    localparam logic [c_STG_W-1:0] c_LAST_STAGE = c_STG_W'(CHANNELS - 1);

    // With a single channel or no gap there is nothing to stagger: every bit
    // drops on the HOLD exit edge and RELEASE is skipped entirely.
    localparam bit c_ONE_SHOT = (CHANNELS == 1) || (STAGE_GAP == 0);

    seq_state_t          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_STG_W-1:0]  r_stage;    // index of the next bit to release
    logic [CHANNELS-1:0] r_rst_out;
    logic                r_ready;

    logic w_req_sync;
    logic w_restart;

    // ------------------------------------------------------------------------
    // Request synchroniser
    // ------------------------------------------------------------------------
    req_sync #(
        .STAGES (REQ_SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (req),
        .o_sync  (w_req_sync)
    );

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
`ifdef RESET_SEQ_WDT_EN
    localparam int c_WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(WDT_CYCLES - 1);

    logic [c_WDT_W-1:0] r_wdt_cnt;
    logic               r_wdt_fired;
    logic               w_wdt_expire;

    // A kick on the terminal cycle still counts as service.
    assign w_wdt_expire = (r_state == RUN) && !wdt_kick && (r_wdt_cnt == c_WDT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdt_cnt   <= '0;
            r_wdt_fired <= 1'b0;
        end else begin
            // Only time spent in RUN counts towards the timeout.
            if ((r_state != RUN) || wdt_kick || w_wdt_expire) begin
                r_wdt_cnt <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
            // Sticky until the next power-on reset so firmware can see why it
            // was restarted.
            if (w_wdt_expire) begin
                r_wdt_fired <= 1'b1;
            end
        end
    end

    assign wdt_fired = r_wdt_fired;
    assign w_restart = w_req_sync | w_wdt_expire;
`else
    assign w_restart = w_req_sync;
`endif

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    // Bits release strictly in order 0,1,2..., so each release is a left shift
    // of the still-asserted mask: 111 -> 110 -> 100 -> 000.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
        end else if (w_restart) begin
            // Holding the counter at 0 while the request persists makes the
            // hold time run from the request's release, not its onset.
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_cnt <= '0;
                        if (c_ONE_SHOT) begin
                            r_rst_out <= '0;
                            r_ready   <= 1'b1;
                            r_state   <= RUN;
                        end else begin
                            r_rst_out <= r_rst_out << 1;
                            r_stage   <= c_STG_W'(1);
                            r_state   <= RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt     <= '0;
                        r_rst_out <= r_rst_out << 1;
                        r_stage   <= r_stage + 1'b1;
                        if (r_stage == c_LAST_STAGE) begin
                            r_ready <= 1'b1;
                            r_state <= RUN;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RUN: begin
                    // Outputs stay static until a restart event.
                end

                default: begin
                    r_state   <= HOLD;
                    r_cnt     <= '0;
                    r_stage   <= '0;
                    r_rst_out <= '1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer. Three instances with
//               different shapes share clk/reset/req:
//                 a: CHANNELS=3 HOLD=10 GAP=4 SYNC=2 (WDT=20 when built in)
//                 b: CHANNELS=4 HOLD=10 GAP=0 SYNC=3
//                 c: CHANNELS=1 HOLD=1  GAP=2 SYNC=2
//               The reference model counts edges since the last restart and
//               derives each output from the release-time formulas.
//               Honours RESET_SEQ_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int A_CH = 3, A_HOLD = 10, A_GAP = 4, A_SYNC = 2, A_WDT = 20;
    localparam int B_CH = 4, B_HOLD = 10, B_GAP = 0, B_SYNC = 3;
    localparam int C_CH = 1, C_HOLD = 1,  C_GAP = 2, C_SYNC = 2;

    logic clk = 1'b0;
    logic reset;
    logic req;
    logic kick;

    logic [A_CH-1:0] rst_a;
    logic [B_CH-1:0] rst_b;
    logic [C_CH-1:0] rst_c;
    logic            ready_a, ready_b, ready_c;
`ifdef RESET_SEQ_WDT_EN
    logic            fired_a, fired_b, fired_c;
`endif

    always #5 clk = ~clk;

    reset_sequencer #(
        .CHANNELS(A_CH), .HOLD_CYCLES(A_HOLD), .STAGE_GAP(A_GAP), .REQ_SYNC_STAGES(A_SYNC)
`ifdef RESET_SEQ_WDT_EN
        , .WDT_CYCLES(A_WDT)
`endif
    ) dut_a (
        .clk(clk), .reset(reset), .req(req),
`ifdef RESET_SEQ_WDT_EN
        .wdt_kick(kick), .wdt_fired(fired_a),
`endif
        .rst_out(rst_a), .ready(ready_a)
    );

    reset_sequencer #(
        .CHANNELS(B_CH), .HOLD_CYCLES(B_HOLD), .STAGE_GAP(B_GAP), .REQ_SYNC_STAGES(B_SYNC)
    ) dut_b (
        .clk(clk), .reset(reset), .req(req),
`ifdef RESET_SEQ_WDT_EN
        .wdt_kick(1'b1), .wdt_fired(fired_b),
`endif
        .rst_out(rst_b), .ready(ready_b)
    );

    reset_sequencer #(
        .CHANNELS(C_CH), .HOLD_CYCLES(C_HOLD), .STAGE_GAP(C_GAP), .REQ_SYNC_STAGES(C_SYNC)
    ) dut_c (
        .clk(clk), .reset(reset), .req(req),
`ifdef RESET_SEQ_WDT_EN
        .wdt_kick(1'b1), .wdt_fired(fired_c),
`endif
        .rst_out(rst_c), .ready(ready_c)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int cnt [3];       // edges since the last restart of each instance
    bit hist [$];      // req samples since the last reset, newest last
    int since_rst = 0;
    int n_edge    = 0;
    int svc       = 0; // edge of last watchdog service / RUN entry (inst a)
    bit m_fired   = 1'b0;

    function automatic int cfg_ch(input int i);
        return (i == 0) ? A_CH : (i == 1) ? B_CH : C_CH;
    endfunction
    function automatic int cfg_hold(input int i);
        return (i == 0) ? A_HOLD : (i == 1) ? B_HOLD : C_HOLD;
    endfunction
    function automatic int cfg_gap(input int i);
        return (i == 0) ? A_GAP : (i == 1) ? B_GAP : C_GAP;
    endfunction
    function automatic int cfg_sync(input int i);
        return (i == 0) ? A_SYNC : (i == 1) ? B_SYNC : C_SYNC;
    endfunction

    // Synchroniser output = req as it was s edges ago, or 0 if reset is closer.
    function automatic bit sync_out(input int s);
        if (since_rst < s) return 1'b0;
        return hist[hist.size() - s];
    endfunction

    function automatic int ready_at(input int i);
        return cfg_hold(i) + (cfg_ch(i) - 1) * cfg_gap(i);
    endfunction

    function automatic logic [31:0] exp_rst(input int i);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < cfg_ch(i); k++) begin
            v[k] = (cnt[i] < cfg_hold(i) + k * cfg_gap(i));
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_ready(input int i);
        return {31'd0, cnt[i] >= ready_at(i)};
    endfunction

    task automatic model_step();
        bit rs [3];
        bit fire;
        for (int i = 0; i < 3; i++) rs[i] = sync_out(cfg_sync(i));
        if (reset) begin
            since_rst = 0;
            hist.delete();
            for (int i = 0; i < 3; i++) cnt[i] = 0;
            m_fired = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                fire = 1'b0;
`ifdef RESET_SEQ_WDT_EN
                if (i == 0) begin
                    bit rdy;
                    rdy  = (cnt[0] >= ready_at(0));
                    fire = rdy && !kick && ((n_edge - svc) == A_WDT);
                    if (kick || !rdy) svc = n_edge;
                    if (fire) m_fired = 1'b1;
                end
`endif
                if (rs[i] || fire) cnt[i] = 0;
                else if (cnt[i] < 100000) cnt[i]++;
            end
            since_rst++;
            hist.push_back(req);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        n_edge++;
    endtask

    task automatic compare_all();
        check_eq("a_rst",   {29'd0, rst_a},   exp_rst(0));
        check_eq("a_ready", {31'd0, ready_a}, exp_ready(0));
        check_eq("b_rst",   {28'd0, rst_b},   exp_rst(1));
        check_eq("b_ready", {31'd0, ready_b}, exp_ready(1));
        check_eq("c_rst",   {31'd0, rst_c},   exp_rst(2));
        check_eq("c_ready", {31'd0, ready_c}, exp_ready(2));
`ifdef RESET_SEQ_WDT_EN
        check_eq("a_fired", {31'd0, fired_a}, {31'd0, m_fired});
        check_eq("b_fired", {31'd0, fired_b}, 32'd0);
        check_eq("c_fired", {31'd0, fired_c}, 32'd0);
`endif
    endtask

    // Inputs change at the falling edge; the model steps right after the
    // rising edge; outputs are compared at the next falling edge.
    task automatic tick(input logic r, input logic q, input logic k);
        reset = r;
        req   = q;
        kick  = k;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        req   = 1'b0;
        kick  = 1'b1;
        @(negedge clk);

        // Power-on reset for 5 cycles.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        check_eq("por_rst_a",   {29'd0, rst_a}, 32'h7);
        check_eq("por_ready_a", {31'd0, ready_a}, 32'd0);

        // Release schedule from the first edge with reset low.
        for (int e = 1; e <= 20; e++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (e == 1)  check_eq("c_rel_e1",   {31'd0, rst_c, ready_c} , 32'h1);
            if (e == 9)  check_eq("a_e9",       {29'd0, rst_a}, 32'h7);
            if (e == 9)  check_eq("b_e9",       {28'd0, rst_b}, 32'hF);
            if (e == 10) check_eq("a_e10",      {29'd0, rst_a}, 32'h6);
            if (e == 10) check_eq("b_e10",      {27'd0, rst_b, ready_b}, 32'h1);
            if (e == 14) check_eq("a_e14",      {29'd0, rst_a}, 32'h4);
            if (e == 17) check_eq("a_ready_e17", {31'd0, ready_a}, 32'd0);
            if (e == 18) check_eq("a_e18",      {28'd0, rst_a, ready_a}, 32'h1);
        end

        // One-cycle req in RUN: reassert three edges later, release 10 edges
        // after the synchronised request falls.
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("req_lat_e2", {31'd0, ready_a}, 32'd1);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("req_lat_e3", {28'd0, rst_a, ready_a}, 32'hE);
        for (int e = 1; e <= 10; e++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (e == 9)  check_eq("rerel_e9",  {29'd0, rst_a}, 32'h7);
            if (e == 10) check_eq("rerel_e10", {29'd0, rst_a}, 32'h6);
        end

        // Request mid-RELEASE (rst_out = 110).
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("mid_rel_e2", {29'd0, rst_a}, 32'h6);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("mid_rel_e3", {29'd0, rst_a}, 32'h7);
        for (int e = 0; e < 25; e++) tick(1'b0, 1'b0, 1'b1);

        // Reset for one cycle in RUN with req held high.
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check_eq("rst_req_a", {28'd0, rst_a, ready_a}, 32'hE);
        for (int e = 0; e < 30; e++) tick(1'b0, 1'b1, 1'b1);
        check_eq("req_held_a", {29'd0, rst_a}, 32'h7);
        for (int e = 0; e < 30; e++) tick(1'b0, 1'b0, 1'b1);

`ifdef RESET_SEQ_WDT_EN
        // Watchdog starved: fires 20 edges after ready.
        tick(1'b1, 1'b0, 1'b1);
        for (int e = 1; e <= 18; e++) tick(1'b0, 1'b0, 1'b1);
        check_eq("wdt_ready", {31'd0, ready_a}, 32'd1);
        for (int e = 1; e <= 20; e++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (e == 19) check_eq("wdt_e19", {28'd0, rst_a, fired_a}, 32'h0);
            if (e == 20) check_eq("wdt_e20", {28'd0, rst_a, fired_a}, 32'hF);
        end
        for (int e = 0; e < 30; e++) tick(1'b0, 1'b0, 1'b1);

        // Kicked every 10 cycles: stays in RUN.
        tick(1'b1, 1'b0, 1'b1);
        for (int e = 0; e < 1000; e++) tick(1'b0, 1'b0, (e % 10) == 0);
        check_eq("wdt_kicked", {30'd0, fired_a, ready_a}, 32'h1);
`endif

        // Randomised traffic: short and long requests, rare resets, sparse kicks.
        for (int e = 0; e < 3000; e++) begin
            logic r, q, k;
            r = ($urandom_range(0, 399) == 0);
            q = ($urandom_range(0, 99) < 3) || (req && ($urandom_range(0, 3) != 0));
            k = ($urandom_range(0, 15) == 0);
            tick(r, q, k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
